udp_tx_arb: RTL and testbench
=============================

# udp_tx_arb

Multi-channel transmit arbiter that sits in front of the UDP send engine in the Ethernet TX clock domain. It lets `CH_NUM` independent producers each request a UDP packet with their own byte count. It grants them round-robin, drives the single `tx_start_en`/`tx_byte_num`/`tx_data` interface of the send engine, and routes `tx_req`/`tx_done` back to the granted producer. It adds a transmit watchdog and a programmable inter-packet gap, which the single-source path lacks.

## Interface
- `CH_NUM`, 4: number of producer channels (2..16).
- `DATA_W`, 32: payload word width, matches the send engine's `tx_data`.
- `LEN_W`, 16: byte-count width.
- `TIMEOUT`, 65535: max cycles in WAIT before abort (≥16).
- `GAP_CYC`, 24: idle cycles after each packet before the next grant (≥1).

- `clk`  in  1  Ethernet TX clock; sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ch_start_en`  in  CH_NUM  per-channel 1-cycle request pulse.
- `ch_byte_num`  in  CH_NUM*LEN_W  per-channel byte count; sampled with `ch_start_en`; channel i is in bits [i*LEN_W +: LEN_W].
- `ch_data`  in  CH_NUM*DATA_W  per-channel payload word; channel i is in bits [i*DATA_W +: DATA_W].
- `ch_req`  out  CH_NUM  per-channel data request, the routed `tx_req`.
- `ch_done`  out  CH_NUM  1-cycle packet-sent pulse.
- `ch_err`  out  CH_NUM  1-cycle pulse: zero-length request rejected, or watchdog abort.
- `ch_pend`  out  CH_NUM  request latched and not yet completed.
- `tx_start_en`  out  1  start pulse to the send engine.
- `tx_byte_num`  out  LEN_W  byte count of the granted channel.
- `tx_data`  out  DATA_W  payload word of the granted channel.
- `tx_ch`  out  clog2(CH_NUM)  index of the granted channel.
- `tx_req`  in  1  data request from the send engine.
- `tx_done`  in  1  packet-complete pulse from the send engine.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Capture**
  - On `ch_start_en[i]` with nonzero length and `ch_pend[i]`=0: set `ch_pend[i]` and latch `len[i]` at the next edge.
  - Zero length: pend stays 0; pulse `ch_err[i]` the next cycle.
  - Start while already pending: ignored, and the latched length is unchanged.
- **FSM:** IDLE → ARB → START → WAIT → GAP → IDLE.
  - IDLE: go to ARB when any `ch_pend` is set.
  - ARB (1 cycle): search from `rr_ptr` upward with wrap. The first pending channel becomes `g`, registered into `tx_ch`.
  - START (1 cycle): `tx_start_en`=1; `tx_byte_num`=`len[g]`, which holds until the next START.
  - WAIT:
    - `ch_req[g]`=`tx_req` combinationally; all other `ch_req` bits are 0.
    - `tx_data`=`ch_data[g]` in every state.
    - `wdog` counts up from 0.
    - On `tx_done`: pulse `ch_done[g]`, clear `ch_pend[g]`, set `rr_ptr`=g+1 (mod CH_NUM), go to GAP.
    - If `wdog` reaches TIMEOUT-1 without `tx_done`: pulse `ch_err[g]`, clear `ch_pend[g]`, advance `rr_ptr` the same way, go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE. `tx_done` arriving here is ignored.
- `tx_done` outside WAIT never affects any pend bit.
- **Simultaneous events**
  - A new `ch_start_en[g]` in the same cycle that `ch_pend[g]` is cleared: the set wins. Pend stays 1 and the new length is latched.
  - Starts on several channels in one cycle are all captured.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, `rr_ptr`=0, all `len` registers 0.
- **Reset mid-packet:** everything returns to reset values at that edge. No `ch_done`/`ch_err` is emitted.
- **Latency from a start pulse in IDLE:**
  - edge 1: pend set;
  - edge 2: ARB;
  - edge 3: START (`tx_start_en` high during cycle 3).
  - Start pulse to `tx_start_en` = 3 cycles.
- `ch_done`/`ch_err` are asserted the cycle after the `tx_done`/timeout edge, for exactly 1 cycle.
- Minimum spacing between two `tx_start_en` pulses = 1 (WAIT) + GAP_CYC + 3.
- `ch_req` has zero latency from `tx_req`. The send engine therefore sees the same request→data timing as when it is driven directly.

## Test plan
- **Single packet:** ch1 start, len=18 → `tx_start_en` 3 cycles later with `tx_byte_num`=18 and `tx_ch`=1. `ch_req[1]` mirrors `tx_req`, and `tx_data`=`ch_data[1]`. A `tx_done` pulse → `ch_done[1]` the next cycle, then 24 GAP cycles, then IDLE.
- **Round robin:** CH_NUM=4, ch0–ch3 all start in the same cycle → grants in order 0,1,2,3. Re-requesting ch0 and ch2 after ch3's grant → grants 0, then 2. No channel is granted twice while another is pending.
- **Zero length / duplicate:** ch2 start with len=0 → `ch_err[2]` pulse and no grant. A second ch3 start with len=99 while pending with len=40 → the packet is sent with 40.
- **Watchdog:** TIMEOUT=100, `tx_done` withheld → `ch_err[g]` 100 cycles after entering WAIT and pend cleared. The next pending channel is granted after the gap.
- **Set-wins:** ch0 `tx_done` in the same cycle as a new ch0 start with len=64 → `ch_done[0]` pulses, `ch_pend[0]` stays 1, and the next ch0 grant carries 64.
- **Reset mid-WAIT:** `rst_n`=0 for 1 cycle during WAIT → all outputs 0 and pend cleared, with no done/err pulse. A fresh start afterwards behaves as in the single-packet case.

Source files
------------

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin arbiter in front of the UDP send engine.
// Latches per-channel requests, grants one packet at a time, and adds a watchdog and an inter-packet gap.
module udp_tx_arb #(
  parameter int CH_NUM  = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 65535,
  parameter int GAP_CYC = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH_NUM-1:0]          ch_start_en,
  input  logic [CH_NUM*LEN_W-1:0]    ch_byte_num,
  input  logic [CH_NUM*DATA_W-1:0]   ch_data,
  output logic [CH_NUM-1:0]          ch_req,
  output logic [CH_NUM-1:0]          ch_done,
  output logic [CH_NUM-1:0]          ch_err,
  output logic [CH_NUM-1:0]          ch_pend,
  output logic                       tx_start_en,
  output logic [LEN_W-1:0]           tx_byte_num,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(CH_NUM)-1:0]  tx_ch,
  input  logic                       tx_req,
  input  logic                       tx_done,
  output logic                       busy
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int IW    = CH_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [CH_NUM-1:0]  r_pend;
  logic [LEN_W-1:0]   r_len [CH_NUM];
  logic [WD_W-1:0]    r_wdog;
  logic [GAP_W-1:0]   r_gap;
  logic [CH_W-1:0]    r_tx_ch;
  logic [LEN_W-1:0]   r_tx_byte_num;
  logic               r_tx_start_en;
  logic [CH_NUM-1:0]  r_ch_done;
  logic [CH_NUM-1:0]  r_ch_err;

  logic               w_found;
  logic [CH_W-1:0]    w_grant;
  logic [CH_W-1:0]    w_rr_next;
  logic [CH_NUM-1:0]  w_sel;
  logic [CH_NUM-1:0]  w_clr;
  logic [CH_NUM-1:0]  w_accept;
  logic [CH_NUM-1:0]  w_zero;
  logic               w_end;

  // Round-robin search: first pending channel at or above rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = {1'b0, r_rr_ptr} + IW'(k);
      if (idx >= IW'(CH_NUM)) idx = idx - IW'(CH_NUM);
      if (!w_found && r_pend[idx[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = idx[CH_W-1:0];
      end
    end
  end

  assign w_end     = (r_state == S_WAIT) && (tx_done || (r_wdog == WD_LAST));
  assign w_rr_next = (r_tx_ch == CH_W'(CH_NUM - 1)) ? '0 : r_tx_ch + 1'b1;

  // A start on a channel being cleared this cycle is accepted: the set wins.
  always_comb begin
    w_sel    = '0;
    w_clr    = '0;
    w_accept = '0;
    w_zero   = '0;
    ch_req   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_sel[i]    = (r_tx_ch == CH_W'(i));
      w_clr[i]    = w_end && w_sel[i];
      w_zero[i]   = ch_start_en[i] && (ch_byte_num[i*LEN_W +: LEN_W] == '0);
      w_accept[i] = ch_start_en[i] && !w_zero[i] && (!r_pend[i] || w_clr[i]);
      ch_req[i]   = tx_req && (r_state == S_WAIT) && w_sel[i];
    end
  end

  // NOTE: state uses non-blocking assignments only; the length registers are
  // reset too, so tx_byte_num never exposes an undefined value after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_pend        <= '0;
      r_wdog        <= '0;
      r_gap         <= '0;
      r_tx_ch       <= '0;
      r_tx_byte_num <= '0;
      r_tx_start_en <= 1'b0;
      r_ch_done     <= '0;
      r_ch_err      <= '0;
      for (int i = 0; i < CH_NUM; i++) r_len[i] <= '0;
    end else begin
      r_ch_done <= '0;
      r_ch_err  <= w_zero;
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_accept[i]) begin
          r_pend[i] <= 1'b1;
          r_len[i]  <= ch_byte_num[i*LEN_W +: LEN_W];
        end else if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (|r_pend) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_tx_ch       <= w_grant;
            r_tx_byte_num <= r_len[w_grant];
            r_tx_start_en <= 1'b1;
            r_state       <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_tx_start_en <= 1'b0;
          r_wdog        <= '0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_end) begin
            r_rr_ptr <= w_rr_next;
            r_gap    <= '0;
            r_state  <= S_GAP;
            if (tx_done) r_ch_done <= w_sel;
            else         r_ch_err  <= w_zero | w_sel;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else                   r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_done     = r_ch_done;
  assign ch_err      = r_ch_err;
  assign ch_pend     = r_pend;
  assign tx_start_en = r_tx_start_en;
  assign tx_byte_num = r_tx_byte_num;
  assign tx_ch       = r_tx_ch;
  assign tx_data     = ch_data[r_tx_ch*DATA_W +: DATA_W];
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: directed scenarios for udp_tx_arb (CH_NUM=4, TIMEOUT=100, GAP_CYC=24).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_udp_tx_arb;

  localparam int CH_NUM  = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 16;
  localparam int TO      = 100;
  localparam int GAP_CYC = 24;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [CH_NUM-1:0]        ch_start_en = '0;
  logic [CH_NUM*LEN_W-1:0]  ch_byte_num = '0;
  logic [CH_NUM*DATA_W-1:0] ch_data = '0;
  logic [CH_NUM-1:0]        ch_req, ch_done, ch_err, ch_pend;
  logic                     tx_start_en;
  logic [LEN_W-1:0]         tx_byte_num;
  logic [DATA_W-1:0]        tx_data;
  logic [1:0]               tx_ch;
  logic                     tx_req = 1'b0;
  logic                     tx_done = 1'b0;
  logic                     busy;

  int n_tests = 0;
  int n_fail  = 0;

  udp_tx_arb #(
    .CH_NUM(CH_NUM), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TO), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start_en(ch_start_en), .ch_byte_num(ch_byte_num), .ch_data(ch_data),
    .ch_req(ch_req), .ch_done(ch_done), .ch_err(ch_err), .ch_pend(ch_pend),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data), .tx_ch(tx_ch),
    .tx_req(tx_req), .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; ch_start_en = '0; tx_req = 1'b0; tx_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_len(input int ch, input logic [LEN_W-1:0] len);
    ch_byte_num[ch*LEN_W +: LEN_W] = len;
  endtask

  // Pulse start on a single channel for one cycle; returns on the falling edge after the capture edge.
  task automatic pulse_start(input int ch, input logic [LEN_W-1:0] len);
    set_len(ch, len);
    ch_start_en = '0;
    ch_start_en[ch] = 1'b1;
    tick();
    ch_start_en = '0;
  endtask

  task automatic wait_start(input int limit, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    while (cyc < limit && !ok) begin
      tick(); cyc++;
      if (tx_start_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    while (cyc < limit && !ok) begin
      tick(); cyc++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  // Called in the START cycle: acknowledge the packet in the first WAIT cycle.
  task automatic ack_packet();
    tick(); tx_done = 1'b1;
    tick(); tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ch_pend !== 4'b0 || ch_done !== 4'b0 || ch_err !== 4'b0 || ch_req !== 4'b0)
      begin n_fail++; $display("FAIL reset_ch: pend=%b done=%b err=%b req=%b want all 0", ch_pend, ch_done, ch_err, ch_req); end
    n_tests++; if (tx_start_en !== 1'b0 || tx_byte_num !== 16'd0 || tx_ch !== 2'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL reset_tx: start=%b num=%0d ch=%0d busy=%b want 0", tx_start_en, tx_byte_num, tx_ch, busy); end
  endtask

  task automatic test_single();
    int cyc; bit ok;
    do_reset();
    for (int i = 0; i < CH_NUM; i++) ch_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 + i;
    pulse_start(1, 16'd18);
    n_tests++; if (ch_pend !== 4'b0010 || busy !== 1'b0)
      begin n_fail++; $display("FAIL single_capture: pend=%b busy=%b want 0010/0", ch_pend, busy); end
    wait_start(10, cyc, ok);
    n_tests++; if (!ok || cyc + 1 != 3)
      begin n_fail++; $display("FAIL single_latency: got %0d cycles (seen=%0b) want 3", cyc + 1, ok); end
    n_tests++; if (tx_byte_num !== 16'd18 || tx_ch !== 2'd1)
      begin n_fail++; $display("FAIL single_grant: num=%0d ch=%0d want 18/1", tx_byte_num, tx_ch); end
    tick();
    n_tests++; if (tx_data !== 32'hA5A5_0001 || tx_start_en !== 1'b0)
      begin n_fail++; $display("FAIL single_data: data=%h start=%b want a5a50001/0", tx_data, tx_start_en); end
    tx_req = 1'b1; #1;
    n_tests++; if (ch_req !== 4'b0010)
      begin n_fail++; $display("FAIL single_req_hi: got %b want 0010", ch_req); end
    tx_req = 1'b0; #1;
    n_tests++; if (ch_req !== 4'b0000)
      begin n_fail++; $display("FAIL single_req_lo: got %b want 0000", ch_req); end
    tx_done = 1'b1;
    tick(); tx_done = 1'b0;
    n_tests++; if (ch_done !== 4'b0010 || ch_pend !== 4'b0000 || ch_err !== 4'b0000)
      begin n_fail++; $display("FAIL single_done: done=%b pend=%b err=%b want 0010/0000/0000", ch_done, ch_pend, ch_err); end
    tick();
    n_tests++; if (ch_done !== 4'b0000 || busy !== 1'b1)
      begin n_fail++; $display("FAIL single_done_pulse: done=%b busy=%b want 0000/1", ch_done, busy); end
    // GAP began at the done edge; one gap cycle has already elapsed here.
    wait_idle(60, cyc, ok);
    n_tests++; if (!ok || cyc != GAP_CYC - 1)
      begin n_fail++; $display("FAIL single_gap: got %0d cycles (idle=%0b) want %0d", cyc, ok, GAP_CYC - 1); end
  endtask

  task automatic test_round_robin();
    int cyc; bit ok;
    int exp_ch [6]  = '{0, 1, 2, 3, 0, 2};
    int exp_len [6] = '{10, 20, 30, 40, 11, 33};
    do_reset();
    set_len(0, 16'd10); set_len(1, 16'd20); set_len(2, 16'd30); set_len(3, 16'd40);
    ch_start_en = 4'b1111;
    tick(); ch_start_en = '0;
    n_tests++; if (ch_pend !== 4'b1111)
      begin n_fail++; $display("FAIL rr_capture: pend=%b want 1111", ch_pend); end
    for (int k = 0; k < 6; k++) begin
      wait_start(60, cyc, ok);
      n_tests++; if (!ok || tx_ch !== 2'(exp_ch[k]) || tx_byte_num !== 16'(exp_len[k]))
        begin n_fail++; $display("FAIL rr_grant%0d: ch=%0d num=%0d seen=%0b want %0d/%0d", k, tx_ch, tx_byte_num, ok, exp_ch[k], exp_len[k]); end
      if (k == 1) begin
        // Back-to-back spacing: 2 cycles to the ack edge plus cyc, expected 1+GAP+3.
        n_tests++; if (cyc + 2 != 1 + GAP_CYC + 3)
          begin n_fail++; $display("FAIL rr_spacing: got %0d want %0d", cyc + 2, 1 + GAP_CYC + 3); end
      end
      tick(); tx_done = 1'b1;
      if (k == 3) begin
        set_len(0, 16'd11); set_len(2, 16'd33);
        ch_start_en = 4'b0101;
      end
      tick(); tx_done = 1'b0; ch_start_en = '0;
    end
    wait_idle(60, cyc, ok);
    n_tests++; if (!ok || ch_pend !== 4'b0000)
      begin n_fail++; $display("FAIL rr_drain: pend=%b idle=%0b want 0000/1", ch_pend, ok); end
  endtask

  task automatic test_zero_dup();
    int cyc; bit ok; bit moved;
    do_reset();
    pulse_start(2, 16'd0);
    n_tests++; if (ch_err !== 4'b0100 || ch_pend !== 4'b0000)
      begin n_fail++; $display("FAIL zero_err: err=%b pend=%b want 0100/0000", ch_err, ch_pend); end
    tick();
    n_tests++; if (ch_err !== 4'b0000)
      begin n_fail++; $display("FAIL zero_err_pulse: err=%b want 0000", ch_err); end
    moved = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy !== 1'b0 || tx_start_en !== 1'b0) moved = 1'b1;
    end
    n_tests++; if (moved !== 1'b0)
      begin n_fail++; $display("FAIL zero_no_grant: activity=%b want 0", moved); end
    set_len(3, 16'd40); ch_start_en = 4'b1000;
    tick();
    set_len(3, 16'd99);
    tick(); ch_start_en = '0;
    wait_start(10, cyc, ok);
    n_tests++; if (!ok || tx_byte_num !== 16'd40 || tx_ch !== 2'd3)
      begin n_fail++; $display("FAIL dup_len: num=%0d ch=%0d seen=%0b want 40/3", tx_byte_num, tx_ch, ok); end
    ack_packet();
    n_tests++; if (ch_done !== 4'b1000 || ch_pend !== 4'b0000)
      begin n_fail++; $display("FAIL dup_done: done=%b pend=%b want 1000/0000", ch_done, ch_pend); end
    wait_idle(60, cyc, ok);
  endtask

  task automatic test_watchdog();
    int cyc; bit ok; bit early;
    do_reset();
    set_len(1, 16'd5); set_len(2, 16'd7);
    ch_start_en = 4'b0110;
    tick(); ch_start_en = '0;
    wait_start(10, cyc, ok);
    n_tests++; if (!ok || tx_ch !== 2'd1)
      begin n_fail++; $display("FAIL wd_grant: ch=%0d seen=%0b want 1", tx_ch, ok); end
    early = 1'b0;
    for (int k = 0; k < TO; k++) begin
      tick();
      if (ch_err !== 4'b0000 || ch_done !== 4'b0000) early = 1'b1;
    end
    n_tests++; if (early !== 1'b0 || ch_pend !== 4'b0110)
      begin n_fail++; $display("FAIL wd_early: early=%b pend=%b want 0/0110", early, ch_pend); end
    tick();
    n_tests++; if (ch_err !== 4'b0010 || ch_pend !== 4'b0100 || ch_done !== 4'b0000)
      begin n_fail++; $display("FAIL wd_abort: err=%b pend=%b done=%b want 0010/0100/0000", ch_err, ch_pend, ch_done); end
    tick(); tx_done = 1'b1;
    n_tests++; if (ch_err !== 4'b0000)
      begin n_fail++; $display("FAIL wd_err_pulse: err=%b want 0000", ch_err); end
    tick(); tx_done = 1'b0;
    n_tests++; if (ch_pend !== 4'b0100 || ch_done !== 4'b0000)
      begin n_fail++; $display("FAIL wd_gap_done: pend=%b done=%b want 0100/0000", ch_pend, ch_done); end
    // Abort edge -> 24 GAP + IDLE + ARB -> START is 27 cycles; 3 already elapsed.
    wait_start(60, cyc, ok);
    n_tests++; if (!ok || cyc != GAP_CYC || tx_ch !== 2'd2 || tx_byte_num !== 16'd7)
      begin n_fail++; $display("FAIL wd_next: cyc=%0d ch=%0d num=%0d want %0d/2/7", cyc, tx_ch, tx_byte_num, GAP_CYC); end
    ack_packet();
    wait_idle(60, cyc, ok);
  endtask

  task automatic test_set_wins();
    int cyc; bit ok;
    do_reset();
    pulse_start(0, 16'd10);
    wait_start(10, cyc, ok);
    n_tests++; if (!ok || tx_ch !== 2'd0 || tx_byte_num !== 16'd10)
      begin n_fail++; $display("FAIL sw_first: ch=%0d num=%0d want 0/10", tx_ch, tx_byte_num); end
    tick();
    tx_done = 1'b1; set_len(0, 16'd64); ch_start_en = 4'b0001;
    tick();
    tx_done = 1'b0; ch_start_en = '0;
    n_tests++; if (ch_done !== 4'b0001 || ch_pend !== 4'b0001)
      begin n_fail++; $display("FAIL sw_pend: done=%b pend=%b want 0001/0001", ch_done, ch_pend); end
    wait_start(60, cyc, ok);
    n_tests++; if (!ok || tx_ch !== 2'd0 || tx_byte_num !== 16'd64)
      begin n_fail++; $display("FAIL sw_regrant: ch=%0d num=%0d seen=%0b want 0/64", tx_ch, tx_byte_num, ok); end
    ack_packet();
    wait_idle(60, cyc, ok);
  endtask

  task automatic test_reset_mid_wait();
    int cyc; bit ok;
    do_reset();
    pulse_start(1, 16'd18);
    wait_start(10, cyc, ok);
    tick(); tx_req = 1'b1; #1;
    n_tests++; if (ch_req !== 4'b0010)
      begin n_fail++; $display("FAIL rmw_req: got %b want 0010", ch_req); end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; #1;
    n_tests++; if (ch_pend !== 4'b0 || ch_done !== 4'b0 || ch_err !== 4'b0 || ch_req !== 4'b0)
      begin n_fail++; $display("FAIL rmw_ch: pend=%b done=%b err=%b req=%b want all 0", ch_pend, ch_done, ch_err, ch_req); end
    n_tests++; if (busy !== 1'b0 || tx_start_en !== 1'b0 || tx_byte_num !== 16'd0 || tx_ch !== 2'd0)
      begin n_fail++; $display("FAIL rmw_tx: busy=%b start=%b num=%0d ch=%0d want 0", busy, tx_start_en, tx_byte_num, tx_ch); end
    tx_req = 1'b0;
    tick();
    n_tests++; if (ch_done !== 4'b0 || ch_err !== 4'b0)
      begin n_fail++; $display("FAIL rmw_quiet: done=%b err=%b want 0000/0000", ch_done, ch_err); end
    pulse_start(1, 16'd18);
    wait_start(10, cyc, ok);
    n_tests++; if (!ok || cyc + 1 != 3 || tx_byte_num !== 16'd18 || tx_ch !== 2'd1)
      begin n_fail++; $display("FAIL rmw_restart: lat=%0d num=%0d ch=%0d want 3/18/1", cyc + 1, tx_byte_num, tx_ch); end
    ack_packet();
    n_tests++; if (ch_done !== 4'b0010)
      begin n_fail++; $display("FAIL rmw_done: done=%b want 0010", ch_done); end
    wait_idle(60, cyc, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dup();
    test_watchdog();
    test_set_wins();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
